// File: rtl/wm8731_cfg_sequencer.sv
// WM8731 configuration sequencer: plays the codec init list over the I2C packet
// master with NACK retries, then forwards single host register writes.
module wm8731_cfg_sequencer #(
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] DEV_BYTE   = 8'h34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_restart,
  input  logic        host_req,
  input  logic [15:0] host_pkt,
  output logic        host_done,
  output logic        host_nack,
  output logic [23:0] i2c_pkt,
  output logic        i2c_start,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        init_done,
  output logic        init_err,
  output logic        busy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]    LAST_IDX  = 4'd10;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_FULL  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GAP, S_INIT_ISSUE, S_INIT_WAIT, S_READY, S_HOST_ISSUE, S_HOST_WAIT, S_ERROR
  } state_t;

  state_t        state_reg, state_next, ret_reg, ret_next;
  logic [3:0]    idx_reg, idx_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [15:0]   host_pkt_reg, host_pkt_next;
  logic          restart_pend_reg, restart_pend_next;
  logic [23:0]   i2c_pkt_reg, i2c_pkt_next;
  logic          i2c_start_reg, i2c_start_next;
  logic          host_done_reg, host_done_next;
  logic          host_nack_reg, host_nack_next;
  logic          init_done_reg, init_done_next;
  logic          init_err_reg, init_err_next;
  logic          idle_state, gap_ok, take_restart;

  function automatic logic [15:0] init_word(input logic [3:0] idx);
    case (idx)
      4'd0:    init_word = {7'h0F, 9'h000};
      4'd1:    init_word = {7'h00, 9'h017};
      4'd2:    init_word = {7'h01, 9'h017};
      4'd3:    init_word = {7'h02, 9'h079};
      4'd4:    init_word = {7'h03, 9'h079};
      4'd5:    init_word = {7'h04, 9'h012};
      4'd6:    init_word = {7'h05, 9'h000};
      4'd7:    init_word = {7'h06, 9'h000};
      4'd8:    init_word = {7'h07, 9'h00E};
      4'd9:    init_word = {7'h08, 9'h000};
      4'd10:   init_word = {7'h09, 9'h001};
      default: init_word = 16'h0000;
    endcase
  endfunction

  assign idle_state = (state_reg == S_READY) || (state_reg == S_ERROR);
  // The gap counter keeps running outside GAP so a host write issued straight
  // from READY still respects the idle time after the last transaction.
  assign gap_ok     = (gap_cnt_reg == GAP_FULL);

  always_comb begin
    state_next        = state_reg;
    ret_next          = ret_reg;
    idx_next          = idx_reg;
    retry_next        = retry_reg;
    gap_cnt_next      = gap_cnt_reg;
    host_pkt_next     = host_pkt_reg;
    restart_pend_next = restart_pend_reg;
    i2c_pkt_next      = i2c_pkt_reg;
    i2c_start_next    = 1'b0;
    host_done_next    = 1'b0;
    host_nack_next    = 1'b0;
    init_done_next    = init_done_reg;
    init_err_next     = init_err_reg;
    take_restart      = 1'b0;

    if (gap_cnt_reg != GAP_FULL) gap_cnt_next = gap_cnt_reg + GW'(1);
    if (init_restart && !idle_state) restart_pend_next = 1'b1;

    unique case (state_reg)
      S_GAP: begin
        if (gap_cnt_reg >= GAP_LAST) begin
          if (restart_pend_reg || init_restart) take_restart = 1'b1;
          else state_next = ret_reg;
        end
      end
      S_INIT_ISSUE: begin
        if (!i2c_busy && gap_ok) begin
          i2c_pkt_next   = {DEV_BYTE, init_word(idx_reg)};
          i2c_start_next = 1'b1;
          state_next     = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT: begin
        if (i2c_done) begin
          gap_cnt_next = '0;
          if (!i2c_nack) begin
            retry_next = '0;
            if (idx_reg == LAST_IDX) begin
              idx_next       = '0;
              init_done_next = 1'b1;
              state_next     = S_READY;
            end else begin
              idx_next   = idx_reg + 4'd1;
              ret_next   = S_INIT_ISSUE;
              state_next = S_GAP;
            end
          end else if (retry_reg < RETRY_MAX) begin
            retry_next = retry_reg + RW'(1);
            ret_next   = S_INIT_ISSUE;
            state_next = S_GAP;
          end else begin
            retry_next    = '0;
            init_err_next = 1'b1;
            state_next    = S_ERROR;
          end
        end
      end
      S_READY, S_ERROR: begin
        if (init_restart || restart_pend_reg) begin
          take_restart = 1'b1;
        end else if (host_req) begin
          host_pkt_next = host_pkt;
          state_next    = S_HOST_ISSUE;
        end
      end
      S_HOST_ISSUE: begin
        if (!i2c_busy && gap_ok) begin
          i2c_pkt_next   = {DEV_BYTE, host_pkt_reg};
          i2c_start_next = 1'b1;
          state_next     = S_HOST_WAIT;
        end
      end
      S_HOST_WAIT: begin
        if (i2c_done) begin
          host_done_next = 1'b1;
          host_nack_next = i2c_nack;
          gap_cnt_next   = '0;
          state_next     = S_GAP;
          // An acknowledged write to the codec reset register wipes the codec,
          // so the whole init list has to be replayed.
          if (!i2c_nack && host_pkt_reg[15:9] == 7'h0F) begin
            idx_next       = '0;
            retry_next     = '0;
            init_done_next = 1'b0;
            init_err_next  = 1'b0;
            ret_next       = S_INIT_ISSUE;
          end else begin
            ret_next = init_err_reg ? S_ERROR : S_READY;
          end
        end
      end
      default: state_next = S_GAP;
    endcase

    if (take_restart) begin
      idx_next          = '0;
      retry_next        = '0;
      init_done_next    = 1'b0;
      init_err_next     = 1'b0;
      restart_pend_next = 1'b0;
      gap_cnt_next      = '0;
      ret_next          = S_INIT_ISSUE;
      state_next        = S_GAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_GAP;
      ret_reg          <= S_INIT_ISSUE;
      idx_reg          <= '0;
      retry_reg        <= '0;
      gap_cnt_reg      <= '0;
      host_pkt_reg     <= '0;
      restart_pend_reg <= 1'b0;
      i2c_pkt_reg      <= '0;
      i2c_start_reg    <= 1'b0;
      host_done_reg    <= 1'b0;
      host_nack_reg    <= 1'b0;
      init_done_reg    <= 1'b0;
      init_err_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ret_reg          <= ret_next;
      idx_reg          <= idx_next;
      retry_reg        <= retry_next;
      gap_cnt_reg      <= gap_cnt_next;
      host_pkt_reg     <= host_pkt_next;
      restart_pend_reg <= restart_pend_next;
      i2c_pkt_reg      <= i2c_pkt_next;
      i2c_start_reg    <= i2c_start_next;
      host_done_reg    <= host_done_next;
      host_nack_reg    <= host_nack_next;
      init_done_reg    <= init_done_next;
      init_err_reg     <= init_err_next;
    end
  end

  assign i2c_pkt   = i2c_pkt_reg;
  assign i2c_start = i2c_start_reg;
  assign host_done = host_done_reg;
  assign host_nack = host_nack_reg;
  assign init_done = init_done_reg;
  assign init_err  = init_err_reg;
  assign busy      = !idle_state;

endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// Bench for wm8731_cfg_sequencer: a behavioural I2C master pops expected packets
// from a scoreboard queue, plus table-driven host writes and corner sequences.
module tb_wm8731_cfg_sequencer;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n, init_restart, host_req;
  logic [15:0] host_pkt;
  logic        host_done, host_nack;
  logic [23:0] i2c_pkt;
  logic        i2c_start, i2c_busy, i2c_done, i2c_nack;
  logic        init_done, init_err, busy;

  wm8731_cfg_sequencer #(.MAX_RETRY(3), .GAP_CYCLES(GAP), .DEV_BYTE(8'h34)) dut (
    .clk(clk), .rst_n(rst_n), .init_restart(init_restart),
    .host_req(host_req), .host_pkt(host_pkt),
    .host_done(host_done), .host_nack(host_nack),
    .i2c_pkt(i2c_pkt), .i2c_start(i2c_start), .i2c_busy(i2c_busy),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .init_done(init_done), .init_err(init_err), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp_q[$];
  bit          nack_q[$];
  int          start_count = 0;
  int          first_start_cyc = 0;
  int          last_done_edge = -1000;
  int          rel_cyc = 0;
  bit          model_active = 1'b0;

  typedef struct {
    logic [15:0] pkt;
    bit          nack_in;
    logic [23:0] exp_pkt;
    bit          exp_nack;
    bit          rerun;
  } host_vec_t;

  logic [23:0] init_pkt[11];
  host_vec_t   host_tab[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] out_view();
    return {2'b00, busy, init_err, init_done, host_nack, host_done, i2c_start, i2c_pkt};
  endfunction

  task automatic model_tick();
    @(posedge clk); #1;
    check("no_start_during_txn", {31'b0, i2c_start}, 32'd0);
  endtask

  // Behavioural I2C packet master with random latency and trailing busy time
  initial begin : i2c_model
    logic [23:0] pkt;
    bit          nack;
    i2c_busy = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (i2c_start === 1'b1) begin
        model_active = 1'b1;
        start_count++;
        if (start_count == 1) first_start_cyc = cyc;
        pkt = i2c_pkt;
        check("gap_after_done", {31'b0, (cyc - last_done_edge) >= GAP + 1}, 32'd1);
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_start: got packet %h required no start (cycle %0d)", pkt, cyc);
        end else begin
          check("i2c_pkt", {8'h0, pkt}, {8'h0, exp_q.pop_front()});
        end
        nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        i2c_busy = 1'b1;
        repeat ($urandom_range(2, 6)) model_tick();
        if (rst_n) check("pkt_stable", {8'h0, i2c_pkt}, {8'h0, pkt});
        i2c_done = 1'b1; i2c_nack = nack; last_done_edge = cyc + 1;
        model_tick();
        i2c_done = 1'b0; i2c_nack = 1'b0;
        repeat ($urandom_range(0, 25)) model_tick();
        i2c_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  // sel: 0 init_done, 1 init_err, 2 host_done, 3 scoreboard drained, 4 start_count>=n
  task automatic wait_cond(input int sel, input int n, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      case (sel)
        0: ok = init_done;
        1: ok = init_err;
        2: ok = host_done;
        3: ok = (exp_q.size() == 0) && !model_active;
        4: ok = (start_count >= n);
        default: ok = 1'b0;
      endcase
      if (ok) break;
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    repeat (hold) @(posedge clk);
    #2;
    exp_q.delete(); nack_q.delete();
    start_count = 0; last_done_edge = -1000;
    rst_n = 1'b1; rel_cyc = cyc;
  endtask

  task automatic push_init(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(init_pkt[i]);
  endtask

  initial begin : watchdog
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    init_pkt = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                 24'h340A00, 24'h340C00, 24'h340E0E, 24'h341000, 24'h341201};
    host_tab[0] = '{16'h0A55, 1'b1, 24'h340A55, 1'b1, 1'b0};
    host_tab[1] = '{16'h1E00, 1'b1, 24'h341E00, 1'b1, 1'b0};
    host_tab[2] = '{16'hFFFF, 1'b0, 24'h34FFFF, 1'b0, 1'b0};
    host_tab[3] = '{16'h1E00, 1'b0, 24'h341E00, 1'b0, 1'b1};
    host_tab[4] = '{16'h0123, 1'b0, 24'h340123, 1'b0, 1'b0};

    // Power-up init with a host write held pending from reset
    rst_n = 1'b0; init_restart = 1'b0; host_req = 1'b1; host_pkt = 16'h0C0A;
    repeat (3) @(posedge clk); #2;
    check("reset_outputs", out_view(), 32'h2000_0000);
    do_reset(2);
    push_init(0, 10);
    exp_q.push_back(24'h340C0A);
    wait_cond(0, 0, 3000, "init_done_seen");
    check("init_done_latency", cyc, last_done_edge);
    check("init_start_count", start_count, 11);
    check("first_start_latency", first_start_cyc - rel_cyc, GAP + 1);
    wait_cond(2, 0, 300, "pending_host_done_seen");
    check("pending_host_nack", {31'b0, host_nack}, 32'd0);
    host_req = 1'b0;
    wait_cond(3, 0, 300, "pending_host_drained");
    check("pending_host_starts", start_count, 12);
    $display("power-up init plus pending host write: %0d starts", start_count);

    // Table-driven host writes from READY
    for (int v = 0; v < 5; v++) begin
      base = start_count;
      exp_q.push_back(host_tab[v].exp_pkt);
      nack_q.push_back(host_tab[v].nack_in);
      if (host_tab[v].rerun) push_init(0, 10);
      host_pkt = host_tab[v].pkt; host_req = 1'b1;
      wait_cond(2, 0, 300, "host_done_seen");
      check("host_done_latency", cyc, last_done_edge);
      check("host_nack", {31'b0, host_nack}, {31'b0, host_tab[v].exp_nack});
      host_req = 1'b0;
      @(posedge clk); #2;
      check("host_done_width", {31'b0, host_done}, 32'd0);
      @(posedge clk); #2;
      check("init_done_after_host", {31'b0, init_done}, {31'b0, !host_tab[v].rerun});
      if (host_tab[v].rerun) wait_cond(0, 0, 3000, "rerun_init_done_seen");
      wait_cond(3, 0, 300, "host_drained");
      check("host_starts", start_count - base, host_tab[v].rerun ? 12 : 1);
      $display("host write %h nack_in=%0d: host_nack=%0d starts=%0d",
               host_tab[v].pkt, host_tab[v].nack_in, host_nack, start_count - base);
    end

    // init_restart during INIT_WAIT of idx 5
    do_reset(3);
    push_init(0, 5);
    push_init(0, 10);
    wait_cond(4, 6, 1000, "idx5_start_seen");
    init_restart = 1'b1;
    @(posedge clk); #2;
    init_restart = 1'b0;
    wait_cond(0, 0, 3000, "restart_init_done_seen");
    wait_cond(3, 0, 300, "restart_drained");
    check("restart_starts", start_count, 17);
    $display("init_restart at idx 5: %0d starts", start_count);

    // Two NACKs on the reg 0x03 packet (list index 4), then ACK
    do_reset(3);
    nack_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    push_init(0, 4); push_init(4, 4); push_init(4, 10);
    wait_cond(0, 0, 3000, "retry_init_done_seen");
    check("retry_init_err", {31'b0, init_err}, 32'd0);
    wait_cond(3, 0, 300, "retry_drained");
    check("retry_starts", start_count, 13);
    $display("nack x2 on 340679: %0d starts, init_done=%0d", start_count, init_done);

    // Four NACKs: init fails and no further starts, host still served from ERROR
    do_reset(3);
    nack_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    push_init(0, 4); push_init(4, 4); push_init(4, 4); push_init(4, 4);
    wait_cond(1, 0, 3000, "init_err_seen");
    check("init_err_latency", cyc, last_done_edge);
    check("err_busy", {31'b0, busy}, 32'd0);
    check("err_init_done", {31'b0, init_done}, 32'd0);
    repeat (150) @(posedge clk);
    #2;
    check("err_no_more_starts", start_count, 8);
    exp_q.push_back(24'h340C0A);
    host_pkt = 16'h0C0A; host_req = 1'b1;
    wait_cond(2, 0, 300, "err_host_done_seen");
    check("err_host_nack", {31'b0, host_nack}, 32'd0);
    host_req = 1'b0;
    wait_cond(3, 0, 300, "err_host_drained");
    check("err_init_err_held", {31'b0, init_err}, 32'd1);
    $display("nack x4 on 340679: init_err=%0d busy=%0d starts=%0d", init_err, busy, start_count);

    // Asynchronous reset during INIT_WAIT of idx 7
    do_reset(3);
    push_init(0, 7);
    wait_cond(4, 8, 1000, "idx7_start_seen");
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", out_view(), 32'h2000_0000);
    do_reset(50);
    push_init(0, 10);
    wait_cond(0, 0, 3000, "post_reset_init_done_seen");
    check("post_reset_first_start", first_start_cyc - rel_cyc, GAP + 1);
    wait_cond(3, 0, 300, "post_reset_drained");
    check("post_reset_starts", start_count, 11);
    $display("reset at idx 7 then re-init: %0d starts", start_count);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
